// File: rtl/elm_pkg.sv
// Shared Q-format constants and saturating arithmetic helpers for the ELM neuron datapath.
package elm_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned FRAC_BITS  = 8;
    localparam int unsigned ACC_WIDTH  = 2 * DATA_WIDTH;

    localparam logic signed [DATA_WIDTH-1:0] DATA_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] DATA_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0]  ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0]  ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // Overflow only when both operands share a sign that the result does not.
    function automatic logic signed [ACC_WIDTH-1:0] sat_add(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic signed [ACC_WIDTH-1:0] b
    );
        logic signed [ACC_WIDTH-1:0] s;
        s = a + b;
        if (!a[ACC_WIDTH-1] && !b[ACC_WIDTH-1] && s[ACC_WIDTH-1]) begin
            return ACC_MAX;
        end
        if (a[ACC_WIDTH-1] && b[ACC_WIDTH-1] && !s[ACC_WIDTH-1]) begin
            return ACC_MIN;
        end
        return s;
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] sat_narrow(
        input logic signed [ACC_WIDTH-1:0] v
    );
        logic signed [ACC_WIDTH-1:0] hi;
        logic signed [ACC_WIDTH-1:0] lo;
        hi = ACC_WIDTH'(DATA_MAX);
        lo = ACC_WIDTH'(DATA_MIN);
        if (v > hi) begin
            return DATA_MAX;
        end
        if (v < lo) begin
            return DATA_MIN;
        end
        return v[DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/elm_sat_accum.sv
// Saturating product accumulator; the final sum of a vector moves to a hold register
// while the accumulator clears on the same edge, so vectors can run back-to-back.
module elm_sat_accum
    import elm_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_valid,
    input  logic                        i_last,
    input  logic signed [ACC_WIDTH-1:0] i_data,
    output logic signed [ACC_WIDTH-1:0] o_hold,
    output logic                        o_hold_valid
);

    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [ACC_WIDTH-1:0] r_hold;
    logic                        r_hold_valid;
    logic signed [ACC_WIDTH-1:0] w_sum;

    assign w_sum = sat_add(r_acc, i_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc        <= '0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
        end else begin
            r_hold_valid <= i_valid & i_last;
            if (i_valid) begin
                if (i_last) begin
                    r_hold <= w_sum;
                    r_acc  <= '0;
                end else begin
                    r_acc  <= w_sum;
                end
            end
        end
    end

    assign o_hold       = r_hold;
    assign o_hold_valid = r_hold_valid;

endmodule

// File: rtl/elm_neuron_mac.sv
// ELM hidden-layer neuron: weight address generation, multiply, saturating accumulate, bias add.
// Optional macro ELM_NEURON_RELU_EN clamps negative results to zero at the output.
module elm_neuron_mac
    import elm_pkg::*;
#(
    parameter int unsigned numWeight    = 784,
    parameter int unsigned addressWidth = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] x_in,
    input  logic                         x_valid,
    input  logic signed [DATA_WIDTH-1:0] bias,
    output logic                         weight_ren,
    output logic [addressWidth:0]        weight_raddr,
    input  logic signed [DATA_WIDTH-1:0] weight_rdata,
    output logic signed [DATA_WIDTH-1:0] out,
    output logic                         out_valid
);

    localparam int unsigned AW = addressWidth + 1;

    logic [AW-1:0]                r_addr;
    logic                         w_at_last;
    logic signed [DATA_WIDTH-1:0] r_x_d;
    logic                         r_v1;
    logic                         r_last1;
    logic signed [ACC_WIDTH-1:0]  r_prod;
    logic                         r_v2;
    logic                         r_last2;
    logic signed [ACC_WIDTH-1:0]  w_hold;
    logic                         w_hold_valid;
    logic signed [ACC_WIDTH-1:0]  w_bias_sh;
    logic signed [ACC_WIDTH-1:0]  w_sum;
    logic signed [DATA_WIDTH-1:0] w_res;
    logic signed [DATA_WIDTH-1:0] w_res_act;
    logic signed [DATA_WIDTH-1:0] r_out;
    logic                         r_out_valid;

    assign weight_ren   = x_valid;
    assign weight_raddr = r_addr;
    assign w_at_last    = (r_addr == AW'(numWeight - 1));

    // Feature is delayed one cycle to line up with the registered weight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_x_d   <= '0;
            r_v1    <= 1'b0;
            r_last1 <= 1'b0;
            r_prod  <= '0;
            r_v2    <= 1'b0;
            r_last2 <= 1'b0;
        end else begin
            if (x_valid) begin
                r_addr <= w_at_last ? '0 : r_addr + AW'(1);
            end
            r_x_d   <= x_in;
            r_v1    <= x_valid;
            r_last1 <= x_valid & w_at_last;
            r_prod  <= ACC_WIDTH'(r_x_d) * ACC_WIDTH'(weight_rdata);
            r_v2    <= r_v1;
            r_last2 <= r_last1;
        end
    end

    elm_sat_accum u_accum (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (r_v2),
        .i_last       (r_last2),
        .i_data       (r_prod),
        .o_hold       (w_hold),
        .o_hold_valid (w_hold_valid)
    );

    assign w_bias_sh = ACC_WIDTH'(bias) <<< FRAC_BITS;
    assign w_sum     = sat_add(w_hold, w_bias_sh);
    assign w_res     = sat_narrow(w_sum >>> FRAC_BITS);

`ifdef ELM_NEURON_RELU_EN
    assign w_res_act = w_res[DATA_WIDTH-1] ? '0 : w_res;
`else
    assign w_res_act = w_res;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_hold_valid;
            if (w_hold_valid) begin
                r_out <= w_res_act;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;

endmodule

// File: doc/elm_neuron_mac.md
Name: elm_neuron_mac

Overview:
- Hidden-layer neuron compute stage that sits directly downstream of a per-neuron weight memory.
- Accepts a stream of signed fixed-point input features and generates the weight memory read address/enable.
- Multiplies each feature by its registered weight, then accumulates with saturation.
- After numWeight inputs, adds the bias and emits one neuron output with a single-cycle valid pulse.

Parameters:
- numWeight, 784, number of inputs (and weights) per output vector.
- addressWidth, 10, weight memory address width; read address port is addressWidth+1 bits.
- dataWidth, 16, width of input, weight, bias and output (signed two's complement).
- fracBits, 8, fractional bits of the shared Q format.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- x_in  input  dataWidth  signed input feature.
- x_valid  input  1  x_in valid this cycle; no backpressure, always accepted.
- bias  input  dataWidth  signed bias; sampled in the bias-add cycle.
- weight_ren  output  1  weight memory read enable.
- weight_raddr  output  addressWidth+1  weight memory read address.
- weight_rdata  input  dataWidth  weight memory data; registered, valid 1 cycle after weight_ren.
- out  output  dataWidth  signed neuron result.
- out_valid  output  1  one-cycle pulse, out valid.

Behaviour:
- Reset values:
  - out=0, out_valid=0, weight_raddr=0 (address counter 0).
  - Pipeline valids=0, accumulator=0.
- Read issue:
  - weight_ren = x_valid (combinational).
  - weight_raddr = registered address counter.
  - Counter increments on each accepted x_valid; wraps numWeight-1 -> 0.
  - A "last" flag is set when counter==numWeight-1 and travels with the sample.
- Pipeline, with x_valid sampled in cycle t:
  - t: x_in registered into x_d; valid and last delayed by 1.
  - t+1: weight_rdata and x_d aligned; full signed product (2*dataWidth bits) registered.
  - t+2: product added into the 2*dataWidth accumulator with saturation to signed min/max.
- Last-product handling:
  - If the product is flagged last, acc+product (saturated) goes into a hold register.
  - The accumulator clears to 0 on the same edge, so back-to-back vectors need no bubble.
- Bias add (cycle t_last+3):
  - sum = sat(hold + (sign-extended bias <<< fracBits)).
  - out = sat_dataWidth(sum >>> fracBits); arithmetic shift, truncation toward -inf.
  - out_valid high in cycle t_last+4, so latency from the last x_valid to out_valid is 4 cycles.
- Gaps in x_valid are allowed anywhere: pipeline stages hold no valid data and the accumulator is unchanged.
- Saturation:
  - Detected by sign of operands vs sign of result.
  - Clamps to 0x7FFF..F / 0x800..0 of the relevant width.
- Reset mid-vector:
  - All partial state is discarded; counter returns to 0.
  - No out_valid is produced for the aborted vector.
- The weight memory write enable is tied low at the instantiating level; this block never writes.

Optional Feature:
- Macro: ELM_NEURON_RELU_EN.
- Defined: out = (result<0) ? 0 : result, applied after saturation, same latency.
- Undefined: out is the signed saturated result, unmodified.

Decomposition:
- Shared package elm_pkg holds:
  - Q-format constants (DATA_WIDTH, FRAC_BITS).
  - Signed max/min constants for dataWidth and 2*dataWidth.
  - A saturating-add function and a saturating-narrow function.
- One sub-module: elm_sat_accum (saturating accumulator with clear-on-last and hold output).
- Multiply and address counter stay in the top.

Test Plan (numWeight=4, fracBits=8):
- Weights 4×0x0100, x=0x0100,0x0200,0x0300,0x0400 on consecutive cycles, bias=0x0080 -> out=0x0A80; out_valid exactly 4 cycles after the 4th x_valid; raddr 0,1,2,3.
- Weights 4×0x7FFF, x 4×0x7FFF, bias=0x7FFF -> accumulator saturates 0x7FFFFFFF, out=0x7FFF, no wrap.
- Weights 0x0100, x=0xFF00×4 (-1.0), bias 0 -> out=0xFC00 without ELM_NEURON_RELU_EN; 0x0000 with it.
- x_valid high 8 consecutive cycles, two vectors -> raddr 0,1,2,3,0,1,2,3; two out_valid pulses 4 cycles apart, each with the correct independent result.
- Same vector as scenario 1 with 1–3 idle cycles between inputs -> out=0x0A80, 4 cycles after the last input.
- rst asserted for 1 cycle after 2 inputs, then a full vector from scenario 1 -> no out_valid for the aborted vector; raddr restarts at 0; out=0x0A80.
